// File: rtl/mesi_isc_pkg.sv
// Shared types and widths for the MESI intersection controller snoop-dispatch path.
// Pure declarations: no latency, no flow control.
package mesi_isc_pkg;

  localparam int NUM_CPU      = 4;
  localparam int CBUS_CMD_W   = 3;
  localparam int ADDR_W       = 32;
  localparam int BROAD_TYPE_W = 2;
  localparam int BROAD_ID_W   = 7;

  typedef enum logic [CBUS_CMD_W-1:0] {
    CBUS_NOP      = 3'd0,
    CBUS_WR_SNOOP = 3'd1,
    CBUS_RD_SNOOP = 3'd2,
    CBUS_EN_WR    = 3'd3,
    CBUS_EN_RD    = 3'd4
  } cbus_cmd_e;

  typedef enum logic [BROAD_TYPE_W-1:0] {
    BREQ_NOP = 2'd0,
    BREQ_WR  = 2'd1,
    BREQ_RD  = 2'd2
  } breq_type_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SNOOP = 2'd1,
    ST_GRANT = 2'd2
  } state_e;

  // Every CPU except the originator has to be snooped.
  function automatic logic [NUM_CPU-1:0] snoop_mask(input logic [1:0] orig);
    logic [NUM_CPU-1:0] m;
    m       = '1;
    m[orig] = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/mesi_isc_snoop_ack_tracker.sv
// Pending-snoop mask: loaded per transaction, bits cleared by acks; all_done flags the last ack.
// Clears take effect on the next edge; acks to non-pending bits are ignored.
module mesi_isc_snoop_ack_tracker
  import mesi_isc_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [NUM_CPU-1:0] load_mask,
  input  logic               track,
  input  logic [NUM_CPU-1:0] ack,
  output logic [NUM_CPU-1:0] pending,
  output logic               all_done
);

  logic [NUM_CPU-1:0] pending_q;
  logic [NUM_CPU-1:0] remaining;

  assign remaining = pending_q & ~ack;
  assign pending   = pending_q;
  assign all_done  = track && (remaining == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
    end else if (load) begin
      pending_q <= load_mask;
    end else if (track) begin
      pending_q <= remaining;
    end
  end

endmodule

// File: rtl/mesi_isc_snoop_dispatch.sv
// Pops broadcast requests, snoops every non-originating CPU, then grants the originator.
// One transaction in flight; stalls indefinitely on missing acks and never pops while busy.
module mesi_isc_snoop_dispatch
  import mesi_isc_pkg::*;
#(
  parameter int CBUS_CMD_WIDTH   = CBUS_CMD_W,
  parameter int ADDR_WIDTH       = ADDR_W,
  parameter int BROAD_TYPE_WIDTH = BROAD_TYPE_W,
  parameter int BROAD_ID_WIDTH   = BROAD_ID_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          broad_fifo_status_empty_i,
  input  logic [ADDR_WIDTH-1:0]         broad_addr_i,
  input  logic [BROAD_TYPE_WIDTH-1:0]   broad_type_i,
  input  logic [1:0]                    broad_cpu_id_i,
  input  logic [BROAD_ID_WIDTH-1:0]     broad_id_i,
  input  logic [NUM_CPU-1:0]            cbus_ack_array_i,
  output logic                          broad_fifo_rd_o,
  output logic [NUM_CPU*CBUS_CMD_WIDTH-1:0] cbus_cmd_array_o,
  output logic [ADDR_WIDTH-1:0]         cbus_addr_o,
  output logic [BROAD_ID_WIDTH-1:0]     cur_id_o,
  output logic                          busy_o
);

  state_e                     state_q, state_d;
  breq_type_e                 type_q;
  logic [1:0]                 cpu_q;
  logic [ADDR_WIDTH-1:0]      addr_q;
  logic [BROAD_ID_WIDTH-1:0]  id_q;

  logic                       pop;
  logic                       load;
  logic                       track;
  logic                       is_req;
  logic [NUM_CPU-1:0]         pending;
  logic                       all_done;
  logic [CBUS_CMD_WIDTH-1:0]  snoop_cmd;
  logic [CBUS_CMD_WIDTH-1:0]  grant_cmd;
  logic [NUM_CPU-1:0][CBUS_CMD_WIDTH-1:0] cmd;

  assign is_req    = (broad_type_i == BREQ_WR) || (broad_type_i == BREQ_RD);
  assign snoop_cmd = (type_q == BREQ_WR) ? CBUS_CMD_WIDTH'(CBUS_WR_SNOOP)
                                         : CBUS_CMD_WIDTH'(CBUS_RD_SNOOP);
  assign grant_cmd = (type_q == BREQ_WR) ? CBUS_CMD_WIDTH'(CBUS_EN_WR)
                                         : CBUS_CMD_WIDTH'(CBUS_EN_RD);

  mesi_isc_snoop_ack_tracker u_ack_tracker (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_mask (snoop_mask(broad_cpu_id_i)),
    .track     (track),
    .ack       (cbus_ack_array_i),
    .pending   (pending),
    .all_done  (all_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    load    = 1'b0;
    track   = 1'b0;
    cmd     = '0;
    case (state_q)
      ST_IDLE: begin
        // Gated by rst so the FIFO is never popped while the controller is held in reset.
        if (!broad_fifo_status_empty_i && !rst) begin
          pop = 1'b1;
          if (is_req) begin
            load    = 1'b1;
            state_d = ST_SNOOP;
          end
        end
      end
      ST_SNOOP: begin
        track = 1'b1;
        for (int i = 0; i < NUM_CPU; i++) begin
          if (pending[i]) cmd[i] = snoop_cmd;
        end
        if (all_done) state_d = ST_GRANT;
      end
      ST_GRANT: begin
        cmd[cpu_q] = grant_cmd;
        if (cbus_ack_array_i[cpu_q]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOP entries are latched too, so addr/id always reflect the most recent pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      type_q <= BREQ_NOP;
      cpu_q  <= '0;
      addr_q <= '0;
      id_q   <= '0;
    end else if (pop) begin
      type_q <= breq_type_e'(broad_type_i);
      cpu_q  <= broad_cpu_id_i;
      addr_q <= broad_addr_i;
      id_q   <= broad_id_i;
    end
  end

  assign broad_fifo_rd_o  = pop;
  assign cbus_cmd_array_o = cmd;
  assign cbus_addr_o      = addr_q;
  assign cur_id_o         = id_q;
  assign busy_o           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mesi_isc_snoop_dispatch.sv
// Directed bench: stimulus pushes per-cycle expected outputs, a negedge monitor pops and compares.
module tb_mesi_isc_snoop_dispatch;

  logic        clk = 1'b0;
  logic        rst;
  logic        empty;
  logic [31:0] addr_in;
  logic [1:0]  type_in;
  logic [1:0]  cpu_in;
  logic [6:0]  id_in;
  logic [3:0]  ack;
  logic        rd;
  logic [11:0] cmd;
  logic [31:0] addr_out;
  logic [6:0]  id_out;
  logic        busy;

  typedef struct {
    int          cyc;
    logic        rd;
    logic [11:0] cmd;
    logic [31:0] addr;
    logic [6:0]  id;
    logic        busy;
  } exp_t;

  exp_t q[$];
  exp_t e;
  logic present;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mesi_isc_snoop_dispatch dut (
    .clk                       (clk),
    .rst                       (rst),
    .broad_fifo_status_empty_i (empty),
    .broad_addr_i              (addr_in),
    .broad_type_i              (type_in),
    .broad_cpu_id_i            (cpu_in),
    .broad_id_i                (id_in),
    .cbus_ack_array_i          (ack),
    .broad_fifo_rd_o           (rd),
    .cbus_cmd_array_o          (cmd),
    .cbus_addr_o               (addr_out),
    .cur_id_o                  (id_out),
    .busy_o                    (busy)
  );

  function automatic logic [11:0] mk(input logic [2:0] c3, input logic [2:0] c2,
                                     input logic [2:0] c1, input logic [2:0] c0);
    return {c3, c2, c1, c0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    ack = 4'b0000;
  endtask

  task automatic head(input logic [1:0] t, input logic [1:0] c, input logic [31:0] a,
                      input logic [6:0] i);
    type_in = t;
    cpu_in  = c;
    addr_in = a;
    id_in   = i;
  endtask

  task automatic expect_ev(input logic r, input logic [11:0] c, input logic [31:0] a,
                           input logic [6:0] i, input logic b);
    exp_t x;
    x.cyc = cyc; x.rd = r; x.cmd = c; x.addr = a; x.id = i; x.busy = b;
    q.push_back(x);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Monitor: the DUT presents output whenever it pops or drives any cbus command.
  always @(negedge clk) begin
    present = rd || (cmd != 12'h0);
    while (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      n_cmp++; n_bad++;
      $display("FAIL missing_event cyc=%0d: nothing seen, required rd=%b cmd=%h", e.cyc, e.rd, e.cmd);
    end
    if (present) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_event cyc=%0d: got rd=%b cmd=%h, required no output", cyc, rd, cmd);
      end else begin
        e = q.pop_front();
        if (e.cyc != cyc || e.rd !== rd || e.cmd !== cmd || e.addr !== addr_out ||
            e.id !== id_out || e.busy !== busy) begin
          n_bad++;
          $display("FAIL event cyc=%0d: got rd=%b cmd=%h addr=%h id=%h busy=%b, required cyc=%0d rd=%b cmd=%h addr=%h id=%h busy=%b",
                   cyc, rd, cmd, addr_out, id_out, busy, e.cyc, e.rd, e.cmd, e.addr, e.id, e.busy);
        end
      end
    end else if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      n_cmp++; n_bad++;
      $display("FAIL missing_event cyc=%0d: nothing seen, required rd=%b cmd=%h", cyc, e.rd, e.cmd);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; empty = 1'b1; ack = 4'b0000;
    head(2'd0, 2'd0, 32'h0, 7'h0);
    #3;
    chk("reset_rd",   32'(rd), 32'h0);
    chk("reset_cmd",  32'(cmd), 32'h0);
    chk("reset_addr", addr_out, 32'h0);
    chk("reset_id",   32'(id_out), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    @(posedge clk); #1; rst = 1'b0;

    // 1: empty FIFO stays quiet
    for (int k = 0; k < 10; k++) tick();
    chk("quiet_busy", 32'(busy), 32'h0);
    chk("quiet_rd",   32'(rd), 32'h0);

    // 2: WR from CPU2, acks one at a time
    head(2'd1, 2'd2, 32'h1000, 7'd5); empty = 1'b0;
    expect_ev(1, 12'h0, 32'h0, 7'd0, 0);
    tick(); empty = 1'b1;
    expect_ev(0, mk(1,0,1,1), 32'h1000, 7'd5, 1); ack = 4'b0001;
    tick(); expect_ev(0, mk(1,0,1,0), 32'h1000, 7'd5, 1); ack = 4'b1000;
    tick(); expect_ev(0, mk(0,0,1,0), 32'h1000, 7'd5, 1); ack = 4'b0010;
    tick(); expect_ev(0, mk(0,3,0,0), 32'h1000, 7'd5, 1);
    tick(); expect_ev(0, mk(0,3,0,0), 32'h1000, 7'd5, 1); ack = 4'b0100;
    tick();
    chk("wr_done_busy", 32'(busy), 32'h0);

    // 3: RD from CPU0, simultaneous acks, FIFO non-empty while busy
    head(2'd2, 2'd0, 32'h2000, 7'd9); empty = 1'b0;
    expect_ev(1, 12'h0, 32'h1000, 7'd5, 0);
    tick(); expect_ev(0, mk(2,2,2,0), 32'h2000, 7'd9, 1); ack = 4'b1110;
    tick(); expect_ev(0, mk(0,0,0,4), 32'h2000, 7'd9, 1); empty = 1'b1; ack = 4'b0001;
    tick();

    // 4: NOP entry dropped, WR popped on the very next cycle
    head(2'd0, 2'd1, 32'h3000, 7'h11); empty = 1'b0;
    expect_ev(1, 12'h0, 32'h2000, 7'd9, 0);
    tick(); head(2'd1, 2'd3, 32'h4000, 7'h22);
    expect_ev(1, 12'h0, 32'h3000, 7'h11, 0);
    tick(); empty = 1'b1;
    // 5: spurious originator ack and repeated ack[1] are ignored
    expect_ev(0, mk(0,1,1,1), 32'h4000, 7'h22, 1); ack = 4'b1000;
    tick(); expect_ev(0, mk(0,1,1,1), 32'h4000, 7'h22, 1); ack = 4'b0010;
    tick(); expect_ev(0, mk(0,1,0,1), 32'h4000, 7'h22, 1); ack = 4'b0010;
    tick(); expect_ev(0, mk(0,1,0,1), 32'h4000, 7'h22, 1); ack = 4'b1001;
    tick(); expect_ev(0, mk(0,1,0,0), 32'h4000, 7'h22, 1); ack = 4'b0100;
    tick(); expect_ev(0, mk(3,0,0,0), 32'h4000, 7'h22, 1); ack = 4'b0100;
    tick(); expect_ev(0, mk(3,0,0,0), 32'h4000, 7'h22, 1); ack = 4'b1000;
    tick();

    // 6: reset during GRANT, then a fresh pop after release
    head(2'd1, 2'd1, 32'h5000, 7'h33); empty = 1'b0;
    expect_ev(1, 12'h0, 32'h4000, 7'h22, 0);
    tick(); empty = 1'b1;
    expect_ev(0, mk(1,1,0,1), 32'h5000, 7'h33, 1); ack = 4'b1101;
    tick(); expect_ev(0, mk(0,0,3,0), 32'h5000, 7'h33, 1);
    @(negedge clk); #1;
    rst = 1'b1;
    head(2'd1, 2'd0, 32'h6000, 7'h44); empty = 1'b0;
    #1;
    chk("rst_grant_cmd",  32'(cmd), 32'h0);
    chk("rst_grant_busy", 32'(busy), 32'h0);
    chk("rst_grant_addr", addr_out, 32'h0);
    chk("rst_grant_id",   32'(id_out), 32'h0);
    chk("rst_grant_rd",   32'(rd), 32'h0);
    @(posedge clk); #1;
    chk("rst_hold_rd", 32'(rd), 32'h0);
    rst = 1'b0;
    expect_ev(1, 12'h0, 32'h0, 7'h0, 0);
    tick(); empty = 1'b1;
    expect_ev(0, mk(1,1,1,0), 32'h6000, 7'h44, 1); ack = 4'b1110;
    tick(); expect_ev(0, mk(0,0,0,3), 32'h6000, 7'h44, 1); ack = 4'b0001;
    tick();
    for (int k = 0; k < 3; k++) tick();
    chk("final_busy", 32'(busy), 32'h0);
    chk("events_left", 32'(q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mesi_isc_snoop_dispatch.md
Name: mesi_isc_snoop_dispatch

Overview:
Consumer end of the broadcast-request path in the MESI intersection controller. Pops one arbitrated broadcast request at a time from the broad FIFO and drives a snoop command on the cbus of every CPU except the originator. After all snooped CPUs acknowledge, it grants the originator (enable-write or enable-read) and waits for that acknowledge. Sits between the broad FIFO and the per-CPU cbus interfaces, mirroring the mbus-side request intake.

Parameters:
CBUS_CMD_WIDTH, 3, width of each per-CPU cbus command
ADDR_WIDTH, 32, broadcast address width
BROAD_TYPE_WIDTH, 2, broadcast type width (NOP/WR/RD)
BROAD_ID_WIDTH, 7, broadcast transaction ID width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
broad_fifo_status_empty_i  in  1  broad FIFO empty; head entry is valid when low (first-word fall-through)
broad_addr_i  in  ADDR_WIDTH  head-entry address
broad_type_i  in  BROAD_TYPE_WIDTH  head-entry type
broad_cpu_id_i  in  2  head-entry originating CPU
broad_id_i  in  BROAD_ID_WIDTH  head-entry transaction ID
cbus_ack_array_i  in  4  per-CPU one-cycle acknowledge
broad_fifo_rd_o  out  1  pop pulse to the broad FIFO
cbus_cmd_array_o  out  4*CBUS_CMD_WIDTH  per-CPU command; CPU i occupies slice [(i+1)*W-1:i*W]
cbus_addr_o  out  ADDR_WIDTH  latched address, shared by all CPUs
cur_id_o  out  BROAD_ID_WIDTH  ID of the transaction in service
busy_o  out  1  high whenever state is not IDLE

Behaviour:
- Reset: state IDLE; all cmd slices NOP; cbus_addr_o=0; cur_id_o=0; broad_fifo_rd_o=0; busy_o=0; pending mask=0.
- cbus commands: NOP=0, WR_SNOOP=1, RD_SNOOP=2, EN_WR=3, EN_RD=4. Breq types: NOP=0, WR=1, RD=2.
- IDLE: when empty=0, broad_fifo_rd_o=1 (combinational, one cycle); addr, type, cpu_id and id are latched on that edge.
  - Type WR or RD: next state SNOOP; pending mask = 4'b1111 with the originator bit cleared.
  - Type NOP: entry is dropped; state stays IDLE, so a pop may occur on consecutive cycles.
- SNOOP:
  - For each CPU i, cmd[i] = WR_SNOOP or RD_SNOOP (by latched type) if pending[i], else NOP. The originator always sees NOP.
  - ack[i] with pending[i] set clears pending[i] at the next edge; cmd[i] is NOP from the following cycle.
  - Acks from non-pending CPUs, including the originator, are ignored.
  - Simultaneous acks clear simultaneously.
  - When the mask would reach 0 at the next edge, next state is GRANT.
- GRANT: cmd[originator] = EN_WR (type WR) or EN_RD (type RD); all other slices NOP. On ack[originator], next state IDLE. A new pop may occur in that IDLE cycle.
- Minimum service latency: pop at cycle 0, snoop commands at cycles 1..k, grant from k+1, IDLE one cycle after the grant ack. There is no timeout; a missing ack stalls indefinitely.
- broad_fifo_rd_o is never asserted outside IDLE or while empty=1. Exactly one transaction is in service at a time.
- cbus_addr_o and cur_id_o hold their value until the next pop.
- Reset mid-transaction aborts immediately to the reset values; the popped entry is lost.

Decomposition:
- Package mesi_isc_pkg:
  - cbus_cmd_e (NOP/WR_SNOOP/RD_SNOOP/EN_WR/EN_RD)
  - breq_type_e (NOP/WR/RD)
  - state_e (IDLE/SNOOP/GRANT)
  - width constants
- Optional sub-module mesi_isc_snoop_ack_tracker: 4-bit pending mask with load, per-bit clear on ack, and all_done output.

Test Plan:
1. Reset, then empty=1 for 10 cycles -> rd=0, all cmds NOP, busy=0.
2. Entry {type=WR, cpu=2, addr=0x1000, id=5}:
   - Pop -> next cycle cmd[0],[1],[3]=1 and cmd[2]=0; addr=0x1000, cur_id=5.
   - Acks on 0, 3, 1 in separate cycles -> cmd[2]=3 one cycle after the last ack.
   - ack[2] -> IDLE.
3. Type RD, cpu=0; all three snoop acks in the same cycle -> cmd[0]=4 on the next cycle; no second pop while busy even with empty=0.
4. Type NOP entry followed by a WR entry -> two consecutive rd pulses; the NOP entry drives no cbus command.
5. Spurious ack[orig] during SNOOP, and repeated ack[1] after it has cleared -> ignored; grant is still issued only after all pending CPUs ack.
6. Assert rst during GRANT -> all outputs return to reset values on the same edge; a fresh entry is popped once rst is released.
